si_byte_frame_decoder: RTL
==========================

Name: si_byte_frame_decoder

Overview:
- Upstream stage of the fully associative request registers.
- Converts the host byte stream (UART/FT245 receiver output) into simple-interface writes `si_addr`/`si_data`/`si_rdy`.
- Assembles one address word and one data word per frame, then pulses `si_rdy` so the addressed request register latches or ORs the data.
- Drops partial frames after an inter-byte timeout so the link resynchronises.

Parameters:
- `ADDR_WIDTH`, default 8: simple-interface address width; `ADDR_BYTES` = ceil(`ADDR_WIDTH`/8).
- `DATA_WIDTH`, default 16: simple-interface data width; `DATA_BYTES` = ceil(`DATA_WIDTH`/8).
- `TIMEOUT_CYCLES`, default 1000000: idle clocks mid-frame before the partial frame is discarded; must be ≥2.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rx_data` in 8: received byte, valid when `rx_rdy`=1.
- `rx_rdy` in 1: one-cycle byte strobe from receiver.
- `si_addr` out `ADDR_WIDTH`: assembled register address.
- `si_data` out `DATA_WIDTH`: assembled register data.
- `si_rdy` out 1: one-cycle write strobe.
- `busy` out 1: frame in progress (at least one byte of the current frame accepted).
- `timeout_err` out 1: one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (`rst`=1 at clock edge):
  - `si_addr`=0, `si_data`=0, `si_rdy`=0, `busy`=0, `timeout_err`=0.
  - Byte counter=0, timeout counter=0, state=`IDLE`.
  - Any partial frame is dropped; reset has priority over all other events.
- Frame format: `ADDR_BYTES` address bytes then `DATA_BYTES` data bytes, each field MSB-first.
  - Each field is shifted in (`field` = {`field`<<8, `rx_data`}) and truncated to its width.
  - Excess upper bits of the first byte are discarded.
- States: `IDLE`, `ADDR`, `DATA`.
  - `IDLE` + `rx_rdy`: load first address byte; go to `ADDR`, or to `DATA` if `ADDR_BYTES`=1.
  - `ADDR` + `rx_rdy`: shift byte in; after the `ADDR_BYTES`-th address byte, go to `DATA`.
  - `DATA` + `rx_rdy`: shift byte in; on the `DATA_BYTES`-th data byte, go to `IDLE` and commit.
- `busy`=1 in `ADDR` and `DATA`, 0 in `IDLE`.
- Assembly registers are internal shadows. `si_addr`/`si_data` change only on commit, so the outputs stay stable between strobes.
- Commit: last byte accepted at edge N gives `si_rdy`=1 during cycle N+1 only, with the new `si_addr`/`si_data` valid that same cycle.
  - Latency from last byte strobe to `si_rdy` is 1 clock.
  - Back-to-back frames are allowed: a byte arriving during the `si_rdy` cycle starts the next frame.
- `si_rdy` is never asserted for an incomplete frame.
- Timeout counter:
  - Cleared on every accepted byte and while in `IDLE`.
  - Increments each clock in `ADDR`/`DATA` without `rx_rdy`, saturating at `TIMEOUT_CYCLES`.
  - When it reaches `TIMEOUT_CYCLES`-1 and no byte arrives: next edge goes to `IDLE`, clears the shadows, and pulses `timeout_err` for one cycle. `si_addr`/`si_data` are unchanged.
- Byte arriving on the same edge the timeout would fire: the byte wins. It is accepted, the counter is cleared, and there is no `timeout_err`.
- `rx_rdy` held high for multiple cycles: each high cycle counts as a new byte. The receiver guarantees single-cycle strobes.
- No backpressure: the downstream request register accepts every strobe.

Test Plan:
- Defaults, `TIMEOUT_CYCLES`=16. Bytes 0x05,0x12,0x34, each a one-cycle strobe 3 clocks apart -> exactly one `si_rdy` pulse, 1 clk after the 0x34 strobe, with `si_addr`=0x05, `si_data`=0x1234. `busy`=1 from the 0x05 edge until the commit edge.
- Two frames back-to-back, strobes every cycle: (0x01,0xAA,0x55) then (0x02,0x00,0x0F) -> `si_rdy` pulses 3 clks apart carrying 0x01/0xAA55 then 0x02/0x000F. Outputs hold 0x02/0x000F afterwards.
- Send 0x07,0x99, then idle 16 clks -> `timeout_err` pulses once, `busy`=0, no `si_rdy`, `si_addr`/`si_data` keep previous values. Then send 0x03,0x00,0x01 -> `si_rdy` with 0x03/0x0001.
- Send 0x07, idle 15 clks, send byte 0x11 on the cycle the timeout would fire, then 0x22 -> no `timeout_err`; `si_rdy` with 0x07/0x1122.
- Send 0x09,0xAB, assert `rst` one cycle, then send 0x04,0xCD,0xEF -> `si_addr`=0, `si_data`=0 after reset; a single `si_rdy` with 0x04/0xCDEF; the pre-reset bytes never appear.
- `ADDR_WIDTH`=4, `DATA_WIDTH`=12: bytes 0xF3,0xAB,0xCD -> `si_addr`=0x3, `si_data`=0xBCD.

Source files
------------

// File: rtl/si_byte_frame_decoder.sv
// Host byte stream to simple-interface write decoder.
// Assembles address/data fields MSB-first and strobes si_rdy per frame.
module si_byte_frame_decoder #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdy,
    output logic [ADDR_WIDTH-1:0] si_addr,
    output logic [DATA_WIDTH-1:0] si_data,
    output logic                  si_rdy,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
    localparam int DATA_BYTES = (DATA_WIDTH + 7) / 8;
    localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int BW         = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DSW        = (DATA_WIDTH > 8) ? DATA_WIDTH - 8 : 1;

    localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_BYTES - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BYTES - 1);
    localparam logic [TW-1:0] TO_FIRE   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [BW-1:0]         byte_cnt, byte_cnt_nxt;
    logic [TW-1:0]         to_cnt, to_cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_sh, addr_sh_nxt;
    logic [DSW-1:0]        data_sh, data_sh_nxt;
    logic [ADDR_WIDTH-1:0] si_addr_nxt;
    logic [DATA_WIDTH-1:0] si_data_nxt;
    logic                  si_rdy_nxt;
    logic                  timeout_nxt;

    logic [ADDR_WIDTH-1:0] addr_shift;
    logic [DATA_WIDTH-1:0] data_full;
    logic [DSW-1:0]        data_keep;

    // The data shadow only keeps the bits that survive the final shift;
    // the last data byte goes straight from rx_data into si_data.
    if (ADDR_WIDTH > 8) begin : g_addr_wide
        assign addr_shift = {addr_sh[ADDR_WIDTH-9:0], rx_data};
    end else begin : g_addr_narrow
        assign addr_shift = rx_data[ADDR_WIDTH-1:0];
    end

    if (DATA_WIDTH > 8) begin : g_data_wide
        assign data_full = {data_sh, rx_data};
        assign data_keep = data_full[DSW-1:0];
    end else begin : g_data_narrow
        assign data_full = rx_data[DATA_WIDTH-1:0];
        assign data_keep = '0;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            to_cnt      <= '0;
            addr_sh     <= '0;
            data_sh     <= '0;
            si_addr     <= '0;
            si_data     <= '0;
            si_rdy      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            byte_cnt    <= byte_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            addr_sh     <= addr_sh_nxt;
            data_sh     <= data_sh_nxt;
            si_addr     <= si_addr_nxt;
            si_data     <= si_data_nxt;
            si_rdy      <= si_rdy_nxt;
            timeout_err <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        to_cnt_nxt   = to_cnt;
        addr_sh_nxt  = addr_sh;
        data_sh_nxt  = data_sh;
        si_addr_nxt  = si_addr;
        si_data_nxt  = si_data;
        si_rdy_nxt   = 1'b0;
        timeout_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                to_cnt_nxt = '0;
                if (rx_rdy) begin
                    // Shadows are always zero here, so this loads the byte.
                    addr_sh_nxt = addr_shift;
                    if (ADDR_BYTES == 1) begin
                        state_nxt    = DATA;
                        byte_cnt_nxt = '0;
                    end else begin
                        state_nxt    = ADDR;
                        byte_cnt_nxt = BW'(1);
                    end
                end
            end
            ADDR: begin
                if (rx_rdy) begin
                    addr_sh_nxt = addr_shift;
                    to_cnt_nxt  = '0;
                    if (byte_cnt == ADDR_LAST) begin
                        state_nxt    = DATA;
                        byte_cnt_nxt = '0;
                    end else begin
                        byte_cnt_nxt = byte_cnt + BW'(1);
                    end
                end else if (to_cnt == TO_FIRE) begin
                    state_nxt    = IDLE;
                    byte_cnt_nxt = '0;
                    to_cnt_nxt   = '0;
                    addr_sh_nxt  = '0;
                    data_sh_nxt  = '0;
                    timeout_nxt  = 1'b1;
                end else if (to_cnt != TO_MAX) begin
                    to_cnt_nxt = to_cnt + TW'(1);
                end
            end
            DATA: begin
                if (rx_rdy) begin
                    to_cnt_nxt = '0;
                    if (byte_cnt == DATA_LAST) begin
                        state_nxt    = IDLE;
                        byte_cnt_nxt = '0;
                        si_addr_nxt  = addr_sh;
                        si_data_nxt  = data_full;
                        si_rdy_nxt   = 1'b1;
                        addr_sh_nxt  = '0;
                        data_sh_nxt  = '0;
                    end else begin
                        data_sh_nxt  = data_keep;
                        byte_cnt_nxt = byte_cnt + BW'(1);
                    end
                end else if (to_cnt == TO_FIRE) begin
                    state_nxt    = IDLE;
                    byte_cnt_nxt = '0;
                    to_cnt_nxt   = '0;
                    addr_sh_nxt  = '0;
                    data_sh_nxt  = '0;
                    timeout_nxt  = 1'b1;
                end else if (to_cnt != TO_MAX) begin
                    to_cnt_nxt = to_cnt + TW'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                byte_cnt_nxt = '0;
                to_cnt_nxt   = '0;
                addr_sh_nxt  = '0;
                data_sh_nxt  = '0;
            end
        endcase
    end

endmodule
